// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the register file with its pending-write scoreboard.
package regfile_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_NREGS  = 4;
    localparam int MAX_NREGS  = 64;

    // Callers zero-extend their NREGS-bit vector to MAX_NREGS bits.
    function automatic int unsigned popcount(input logic [MAX_NREGS-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < MAX_NREGS; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write bits: issue sets, writeback clears, set wins on the same index.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = DEF_NREGS,
    parameter int AW       = $clog2(NREGS),
    parameter bit ZERO_REG = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fire,
    input  logic             iss_wr,
    input  logic [AW-1:0]    iss_rd,
    input  logic             we,
    input  logic [AW-1:0]    rd,
    output logic [NREGS-1:0] pend,
    output logic             waw,
    output logic [AW:0]      pend_cnt
);

    localparam int CW = AW + 1;

    logic [NREGS-1:0] pend_d, pend_q;
    logic [AW:0]      pend_cnt_d, pend_cnt_q;

    always_comb begin
        pend_d = pend_q;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (we && rd == AW'(i))                pend_d[i] = 1'b0;
            if (fire && iss_wr && iss_rd == AW'(i)) pend_d[i] = 1'b1;
        end
        if (ZERO_REG) pend_d[0] = 1'b0;
        pend_cnt_d = CW'(popcount(MAX_NREGS'(pend_d)));
    end

    // A writeback landing this cycle on the destination resolves the WAW hazard.
    assign waw = iss_wr & pend_q[iss_rd] & ~(we && rd == iss_rd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend     = pend_q;
    assign pend_cnt = pend_cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with same-cycle write bypass and RAW/WAW stall generation.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NREGS    = DEF_NREGS,
    parameter int AW       = $clog2(NREGS),
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     rs1,
    input  logic [AW-1:0]     rs2,
    input  logic              use1,
    input  logic              use2,
    input  logic              iss_valid,
    input  logic              iss_wr,
    input  logic [AW-1:0]     iss_rd,
    input  logic              we,
    input  logic [AW-1:0]     rd,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] dout1,
    output logic [DATA_W-1:0] dout2,
    output logic              busy1,
    output logic              busy2,
    output logic              stall,
    output logic [AW:0]       pend_cnt
);

    logic [NREGS-1:0][DATA_W-1:0] rf_d, rf_q;
    logic [NREGS-1:0]             pend;
    logic                         waw, fire;
    logic                         byp1, byp2, zero1, zero2;

    always_comb begin
        rf_d = rf_q;
        if (we && !(ZERO_REG && rd == '0)) rf_d[rd] = wd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rf_q <= '0;
        else       rf_q <= rf_d;
    end

    always_comb begin
        byp1  = BYPASS && we && (rd == rs1);
        byp2  = BYPASS && we && (rd == rs2);
        zero1 = ZERO_REG && (rs1 == '0);
        zero2 = ZERO_REG && (rs2 == '0);
        dout1 = zero1 ? '0 : (byp1 ? wd : rf_q[rs1]);
        dout2 = zero2 ? '0 : (byp2 ? wd : rf_q[rs2]);
        busy1 = pend[rs1] & ~byp1;
        busy2 = pend[rs2] & ~byp2;
        stall = iss_valid & ((use1 & busy1) | (use2 & busy2) | waw);
        fire  = iss_valid & ~stall;
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .fire     (fire),
        .iss_wr   (iss_wr),
        .iss_rd   (iss_rd),
        .we       (we),
        .rd       (rd),
        .pend     (pend),
        .waw      (waw),
        .pend_cnt (pend_cnt)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: stimulus queues expected outputs, a negedge monitor pops and compares.
module tb_regfile_sb;

    typedef struct {
        string       name;
        logic [15:0] d1;
        logic [15:0] d2;
        logic        b1;
        logic        b2;
        logic        st;
        logic [3:0]  cnt;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance A: defaults (8-bit, 4 regs, no zero register, bypass on)
    logic [1:0] a_rs1, a_rs2, a_iss_rd, a_rd;
    logic       a_use1, a_use2, a_iss_valid, a_iss_wr, a_we;
    logic [7:0] a_wd, a_dout1, a_dout2;
    logic       a_busy1, a_busy2, a_stall;
    logic [2:0] a_pend_cnt;

    regfile_sb dut_a (
        .clk(clk), .reset(reset), .rs1(a_rs1), .rs2(a_rs2), .use1(a_use1), .use2(a_use2),
        .iss_valid(a_iss_valid), .iss_wr(a_iss_wr), .iss_rd(a_iss_rd), .we(a_we), .rd(a_rd),
        .wd(a_wd), .dout1(a_dout1), .dout2(a_dout2), .busy1(a_busy1), .busy2(a_busy2),
        .stall(a_stall), .pend_cnt(a_pend_cnt)
    );

    // Instance B: 16-bit, 8 regs, register 0 hardwired to zero
    logic [2:0]  b_rs1, b_rs2, b_iss_rd, b_rd;
    logic        b_use1, b_use2, b_iss_valid, b_iss_wr, b_we;
    logic [15:0] b_wd, b_dout1, b_dout2;
    logic        b_busy1, b_busy2, b_stall;
    logic [3:0]  b_pend_cnt;

    regfile_sb #(.DATA_W(16), .NREGS(8), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_b (
        .clk(clk), .reset(reset), .rs1(b_rs1), .rs2(b_rs2), .use1(b_use1), .use2(b_use2),
        .iss_valid(b_iss_valid), .iss_wr(b_iss_wr), .iss_rd(b_iss_rd), .we(b_we), .rd(b_rd),
        .wd(b_wd), .dout1(b_dout1), .dout2(b_dout2), .busy1(b_busy1), .busy2(b_busy2),
        .stall(b_stall), .pend_cnt(b_pend_cnt)
    );

    task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %h expected %h", nm, fld, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk(e.name, "dout1", {8'h00, a_dout1}, e.d1);
                chk(e.name, "dout2", {8'h00, a_dout2}, e.d2);
                chk(e.name, "busy1", {15'h0, a_busy1}, {15'h0, e.b1});
                chk(e.name, "busy2", {15'h0, a_busy2}, {15'h0, e.b2});
                chk(e.name, "stall", {15'h0, a_stall}, {15'h0, e.st});
                chk(e.name, "pend_cnt", {13'h0, a_pend_cnt}, {12'h0, e.cnt});
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk(e.name, "dout1", b_dout1, e.d1);
                chk(e.name, "dout2", b_dout2, e.d2);
                chk(e.name, "busy1", {15'h0, b_busy1}, {15'h0, e.b1});
                chk(e.name, "busy2", {15'h0, b_busy2}, {15'h0, e.b2});
                chk(e.name, "stall", {15'h0, b_stall}, {15'h0, e.st});
                chk(e.name, "pend_cnt", {12'h0, b_pend_cnt}, e.cnt);
            end
        end
    end

    // One cycle on A: drive just after the edge, queue the response expected before the next edge.
    task automatic sa(input string nm, input logic rst,
                      input logic [1:0] r1, input logic [1:0] r2, input logic u1, input logic u2,
                      input logic iv, input logic iw, input logic [1:0] ird,
                      input logic w, input logic [1:0] wr, input logic [7:0] wdat,
                      input logic [7:0] e1, input logic [7:0] e2,
                      input logic eb1, input logic eb2, input logic est, input logic [2:0] ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        a_rs1 = r1; a_rs2 = r2; a_use1 = u1; a_use2 = u2;
        a_iss_valid = iv; a_iss_wr = iw; a_iss_rd = ird;
        a_we = w; a_rd = wr; a_wd = wdat;
        e.name = nm; e.d1 = {8'h00, e1}; e.d2 = {8'h00, e2};
        e.b1 = eb1; e.b2 = eb2; e.st = est; e.cnt = {1'b0, ecnt};
        qa.push_back(e);
    endtask

    task automatic sb(input string nm,
                      input logic [2:0] r1, input logic [2:0] r2, input logic u1, input logic u2,
                      input logic iv, input logic iw, input logic [2:0] ird,
                      input logic w, input logic [2:0] wr, input logic [15:0] wdat,
                      input logic [15:0] e1, input logic [15:0] e2,
                      input logic eb1, input logic eb2, input logic est, input logic [3:0] ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        b_rs1 = r1; b_rs2 = r2; b_use1 = u1; b_use2 = u2;
        b_iss_valid = iv; b_iss_wr = iw; b_iss_rd = ird;
        b_we = w; b_rd = wr; b_wd = wdat;
        e.name = nm; e.d1 = e1; e.d2 = e2;
        e.b1 = eb1; e.b2 = eb2; e.st = est; e.cnt = ecnt;
        qb.push_back(e);
    endtask

    initial begin : stim
        int unsigned budget;
        a_rs1 = '0; a_rs2 = '0; a_use1 = 0; a_use2 = 0; a_iss_valid = 0; a_iss_wr = 0;
        a_iss_rd = '0; a_we = 0; a_rd = '0; a_wd = '0;
        b_rs1 = '0; b_rs2 = '0; b_use1 = 0; b_use2 = 0; b_iss_valid = 0; b_iss_wr = 0;
        b_iss_rd = '0; b_we = 0; b_rd = '0; b_wd = '0;

        //   name        rst rs1 rs2 u1 u2 iv iw ird we rd wd     | d1     d2     b1 b2 st cnt
        sa("reset",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00,  8'h00, 8'h00, 0, 0, 0, 0);
        sa("wb_bypass",  0, 2, 0, 0, 0, 0, 0, 0, 1, 2, 8'hA5,  8'hA5, 8'h00, 0, 0, 0, 0);
        sa("wb_read",    0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00,  8'hA5, 8'h00, 0, 0, 0, 0);
        sa("iss_r1",     0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 8'h00,  8'h00, 8'h00, 0, 0, 0, 0);
        sa("raw_stall",  0, 1, 2, 1, 0, 1, 0, 0, 0, 0, 8'h00,  8'h00, 8'hA5, 1, 0, 1, 1);
        sa("raw_clear",  0, 1, 2, 1, 0, 1, 0, 0, 1, 1, 8'h3C,  8'h3C, 8'hA5, 0, 0, 0, 1);
        sa("raw_after",  0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 8'h00,  8'h3C, 8'hA5, 0, 0, 0, 0);
        sa("iss_r3",     0, 3, 0, 0, 0, 1, 1, 3, 0, 0, 8'h00,  8'h00, 8'h00, 0, 0, 0, 0);
        sa("waw_stall",  0, 3, 0, 0, 0, 1, 1, 3, 0, 0, 8'h00,  8'h00, 8'h00, 1, 0, 1, 1);
        sa("waw_clear",  0, 3, 0, 0, 0, 1, 1, 3, 1, 3, 8'h77,  8'h77, 8'h00, 0, 0, 0, 1);
        sa("waw_reset",  0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00,  8'h77, 8'h00, 1, 0, 0, 1);
        sa("setclr_r0",  0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 8'h5A,  8'h5A, 8'h5A, 0, 0, 0, 1);
        sa("setclr_aft", 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 8'h00,  8'h5A, 8'h77, 1, 1, 0, 2);
        sa("iss_r2",     0, 2, 1, 0, 0, 1, 1, 2, 0, 0, 8'h00,  8'hA5, 8'h3C, 0, 0, 0, 2);
        sa("three_pend", 0, 2, 0, 1, 1, 1, 0, 0, 0, 0, 8'h00,  8'hA5, 8'h5A, 1, 1, 1, 3);
        sa("mid_reset",  1, 2, 0, 1, 1, 1, 1, 3, 0, 0, 8'h00,  8'h00, 8'h00, 0, 0, 0, 0);
        sa("rel_reset",  0, 2, 3, 1, 1, 1, 0, 0, 0, 0, 8'h00,  8'h00, 8'h00, 0, 0, 0, 0);
        sa("post_wr",    0, 1, 3, 0, 0, 0, 0, 0, 1, 1, 8'h11,  8'h11, 8'h00, 0, 0, 0, 0);
        sa("post_rd",    0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 8'h00,  8'h11, 8'h00, 0, 0, 0, 0);

        //   name        rs1 rs2 u1 u2 iv iw ird we rd wd        | d1        d2        b1 b2 st cnt
        sb("z_idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
        sb("z_wr0",      0, 0, 0, 0, 0, 0, 0, 1, 0, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 0, 0);
        sb("z_iss0",     0, 0, 1, 0, 1, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
        sb("z_reiss0",   0, 0, 1, 1, 1, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
        sb("z_wr5_iss7", 5, 0, 0, 0, 1, 1, 7, 1, 5, 16'h1234, 16'h1234, 16'h0000, 0, 0, 0, 0);
        sb("z_raw7",     5, 7, 0, 1, 1, 0, 0, 0, 0, 16'h0000, 16'h1234, 16'h0000, 0, 1, 1, 1);

        budget = 0;
        while ((qa.size() > 0 || qb.size() > 0) && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        if (qa.size() > 0 || qb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending %0d expected 0", qa.size() + qb.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port register file with a built-in pending-write scoreboard and same-cycle write-to-read bypass, serving as the pipeline's architectural register storage. Decode reads operands and asks the scoreboard whether they are pending. Issue marks the destination register busy. Writeback writes data and clears the busy bit. The block produces a combinational `stall` so decode holds on RAW and WAW hazards without external tracking logic.

## Interface
- `DATA_W`, 8, register width in bits
- `NREGS`, 4, number of registers (power of two, ≥2)
- `AW`, $clog2(NREGS), register index width (derived; do not override)
- `ZERO_REG`, 0, if 1: register 0 reads as zero, ignores writes, never busy
- `BYPASS`, 1, if 1: same-cycle writeback data is forwarded to the read ports

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `rs1`, `rs2`  in  AW  read indices
- `use1`, `use2`  in  1  operand actually consumed by the issuing instruction
- `iss_valid`  in  1  decode is attempting to issue this cycle
- `iss_wr`  in  1  issuing instruction writes a destination
- `iss_rd`  in  AW  destination of the issuing instruction
- `we`  in  1  writeback valid
- `rd`  in  AW  writeback index
- `wd`  in  DATA_W  writeback data
- `dout1`, `dout2`  out  DATA_W  read data
- `busy1`, `busy2`  out  1  operand still pending after bypass
- `stall`  out  1  issue blocked this cycle
- `pend_cnt`  out  AW+1  number of busy registers

## Operation
- **Storage.** `rf[NREGS]` of DATA_W bits and `pend[NREGS]` of 1 bit.
- **Reads** are combinational.
  - `dout1 = (BYPASS && we && rd==rs1) ? wd : rf[rs1]`; `dout2` is symmetric.
- **Busy.** `busy1 = pend[rs1] & ~(BYPASS && we && rd==rs1)`; `busy2` is symmetric.
- **Stall.** `stall = iss_valid & ((use1&busy1) | (use2&busy2) | (iss_wr & pend[iss_rd] & ~(we && rd==iss_rd)))`.
  - The third term is the WAW hazard.
- **Issue fire.** `fire = iss_valid & ~stall`.
  - On `fire & iss_wr`, set `pend[iss_rd]` at the next edge.
- **Writeback.** On `we`, write `rf[rd] <= wd` and clear `pend[rd]`.
  - A writeback to a non-pending register is legal: data is written and `pend` stays 0.
- **Same index, same cycle.** If issue and writeback hit the same index in one cycle, set wins: `pend` ends at 1 and the data is still written.
- **ZERO_REG=1:**
  - index 0 reads 0 on both ports, including under bypass;
  - writes to index 0 are dropped;
  - `pend[0]` is forced to 0, so `busy` and `stall` never assert for index 0.
- **pend_cnt** is a registered popcount of `pend`, updated every edge.
  - Range is 0..NREGS; it cannot wrap, which is why it is AW+1 bits wide.
- **BYPASS=0.** Reads return the old `rf` value during a same-cycle write, and `busy` reflects the raw `pend`.
  - The WAW term still honours the same-cycle clear.

## Timing
- **Reset** (async assert, any cycle, including mid-issue):
  - all `rf` = 0, all `pend` = 0, `pend_cnt` = 0;
  - `busy1`/`busy2`/`stall` = 0 (unless driven by inputs against the cleared state, which yields 0);
  - `dout1`/`dout2` = 0.
  - Reset is released synchronously to `clk` by the system.
- **Read latency:** 0 cycles, combinational from `rs*`.
- **Write latency:** 1 edge. Visible in `rf` from the next cycle, and in the same cycle through bypass.
- **Scoreboard:** a set is visible to `busy`/`stall` from the cycle after fire. A clear takes effect combinationally in the writeback cycle when BYPASS=1.
- **No registered path** from inputs to `stall`. Decode must sample `stall` in the same cycle.

## Structure
- Package `regfile_pkg` holds:
  - `DEF_DATA_W = 8` and `DEF_NREGS = 4`;
  - a function for popcount of a `NREGS`-bit vector.
- Sub-module `regfile_scoreboard` owns:
  - `pend`, the set/clear priority, ZERO_REG masking for `pend`, `pend_cnt`, and the WAW term.
- Top level owns `rf`, the bypass muxes, and the `busy`/`stall` assembly.

## Test plan
- **Reset + writeback.** Reset, then write `rd=2`, `wd=8'hA5`; next cycle `rs1=2` -> `dout1=8'hA5`, `busy1=0`, `pend_cnt=0`.
- **RAW stall and release.** Fire issue `iss_rd=1`; next cycle `iss_valid`, `use1`, `rs1=1` -> `stall=1`, `pend_cnt=1`. Writeback `rd=1`, `wd=8'h3C` in the same cycle -> `stall=0`, `dout1=8'h3C` (BYPASS=1).
- **WAW.** With `pend[3]=1`, issue `iss_wr` with `iss_rd=3` -> `stall=1`, `pend` unchanged. Then `we`, `rd=3` -> `stall=0` and fire sets `pend[3]`, so it ends at 1.
- **Simultaneous set/clear same index.** Writeback and fire on index 0 (ZERO_REG=0) -> `rf[0]=wd`, `pend[0]=1`.
- **ZERO_REG=1, NREGS=8, DATA_W=16.** Write `16'hFFFF` to index 0, then fire issue to index 0 -> `dout1=0`, `pend_cnt=0`, `stall` never asserts.
- **Reset mid-operation.** With 3 registers pending and nonzero data, assert `reset` between edges -> all outputs 0 immediately; stays 0 after release until the first write.
